// File: rtl/conv_stream_monitor.sv
// Capture/monitor for the convolution output stream: counts beats, sums and min/max-tracks
// all lanes of one frame, and reports end-of-frame, length errors and start timeout.
module conv_stream_monitor #(
    parameter int DATA_W     = 16,
    parameter int CHANNELS   = 1,
    parameter int CNT_W      = 20,
    parameter int GAP_CYCLES = 1,
    parameter int EXP_COUNT  = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         valid_i,
    input  logic [CHANNELS*DATA_W-1:0]   data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             count_o,
    output logic [31:0]                  checksum_o,
    output logic [DATA_W-1:0]            min_o,
    output logic [DATA_W-1:0]            max_o,
    output logic                         err_short_o,
    output logic                         err_long_o,
    output logic                         err_timeout_o
);

    typedef enum logic [2:0] {IDLE, WAIT_FIRST, CAPTURE, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_COUNT);
    localparam logic [31:0]      GAP_C   = 32'(GAP_CYCLES);
    localparam logic [31:0]      TIMEOUT_C = 32'(TIMEOUT);

    state_t             state, state_next;
    logic [31:0]        tcnt, tcnt_next;
    logic [31:0]        gcnt, gcnt_next;
    logic               accept, clear, timeout_hit, enter_done;
    logic [31:0]        beat_sum;
    logic [DATA_W-1:0]  beat_min, beat_max, lane;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Per-beat reduction across all lanes, unsigned
    always_comb begin
        beat_sum = '0;
        beat_min = '1;
        beat_max = '0;
        lane     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            lane     = data_i[k*DATA_W +: DATA_W];
            beat_sum = beat_sum + 32'(lane);
            if (lane < beat_min) beat_min = lane;
            if (lane > beat_max) beat_max = lane;
        end
    end

    always_comb begin
        state_next  = state;
        tcnt_next   = tcnt;
        gcnt_next   = gcnt;
        accept      = 1'b0;
        clear       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    clear      = 1'b1;
                    tcnt_next  = '0;
                    gcnt_next  = '0;
                    state_next = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (valid_i) begin
                    accept     = 1'b1;
                    state_next = CAPTURE;
                end else begin
                    tcnt_next = tcnt + 32'd1;
                    if (TIMEOUT != 0 && tcnt + 32'd1 == TIMEOUT_C) begin
                        timeout_hit = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            CAPTURE: begin
                if (valid_i) begin
                    accept = 1'b1;
                end else if (GAP_CYCLES <= 1) begin
                    state_next = DONE;
                end else begin
                    gcnt_next  = 32'd1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (valid_i) begin
                    accept     = 1'b1;
                    gcnt_next  = '0;
                    state_next = CAPTURE;
                end else if (gcnt + 32'd1 >= GAP_C) begin
                    state_next = DONE;
                end else begin
                    gcnt_next = gcnt + 32'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_done = (state_next == DONE) && (state != DONE);
    assign busy_o     = (state == WAIT_FIRST) || (state == CAPTURE) || (state == GAP);
    assign done_o     = (state == DONE);

    // Stats update one edge after the beat is sampled; length flags latch as DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            gcnt          <= '0;
            count_o       <= '0;
            checksum_o    <= '0;
            min_o         <= '1;
            max_o         <= '0;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            gcnt  <= gcnt_next;
            if (clear) begin
                count_o       <= '0;
                checksum_o    <= '0;
                min_o         <= '1;
                max_o         <= '0;
                err_short_o   <= 1'b0;
                err_long_o    <= 1'b0;
                err_timeout_o <= 1'b0;
            end
            if (accept) begin
                count_o    <= sat_inc(count_o);
                checksum_o <= checksum_o + beat_sum;
                if (beat_min < min_o) min_o <= beat_min;
                if (beat_max > max_o) max_o <= beat_max;
            end
            if (enter_done) begin
                err_short_o <= (EXP_COUNT != 0) && (count_o < EXP_C);
                err_long_o  <= (EXP_COUNT != 0) && (count_o > EXP_C);
            end
            if (timeout_hit) err_timeout_o <= 1'b1;
        end
    end

endmodule
